// File: rtl/bsg_manycore_ready_to_credit_tx.sv
// Valid/ready_and to credit-based valid-only transmit converter with a small input FIFO.
// Optional macro BSG_MANYCORE_CREDIT_TX_OVERFLOW_CHECK_EN enables the sticky credit-overflow flag.
module bsg_manycore_ready_to_credit_tx
  #(parameter int width_p      = 32
   ,parameter int credit_els_p = 3
   ,parameter int buf_els_p    = 2
   ,localparam int cnt_width_lp = ((credit_els_p + 1) > 1) ? $clog2(credit_els_p + 1) : 1)
  (input  logic                    clk_i
  ,input  logic                    reset_n_i
  ,input  logic                    v_i
  ,input  logic [width_p-1:0]      data_i
  ,output logic                    ready_and_o
  ,output logic                    v_o
  ,output logic [width_p-1:0]      data_o
  ,input  logic                    credit_i
  ,output logic [cnt_width_lp-1:0] credits_o
  ,output logic                    drained_o
  ,output logic                    error_o
  );

  localparam logic [cnt_width_lp-1:0] lp_credit_max = cnt_width_lp'(credit_els_p);
  localparam logic [cnt_width_lp-1:0] lp_cnt_one    = cnt_width_lp'(1);
  localparam logic [1:0]              lp_buf_full   = 2'(buf_els_p);

  logic [width_p-1:0]      r_mem [buf_els_p];
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [1:0]              r_count;
  logic [cnt_width_lp-1:0] r_credits;
  logic                    r_v;
  logic [width_p-1:0]      r_data;
  logic                    r_ready;
  logic                    r_drained;

  logic                    w_enq;
  logic                    w_send;
  logic                    w_overflow;
  logic [1:0]              w_count_next;
  logic [cnt_width_lp-1:0] w_credits_next;

  // A one-entry buffer keeps both pointers pinned at zero.
  function automatic logic f_ptr_inc(input logic ptr);
    return (buf_els_p == 1) ? 1'b0 : ~ptr;
  endfunction

  assign w_enq      = v_i & (r_count != lp_buf_full);
  assign w_send     = (r_count != 2'd0) & (r_credits != {cnt_width_lp{1'b0}});
  assign w_overflow = credit_i & ~w_send & (r_credits == lp_credit_max);

  // Next buffer occupancy from enqueue/dequeue this cycle.
  always_comb begin
    w_count_next = r_count;
    case ({w_enq, w_send})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // Next credit count; an overflowing credit is dropped so the counter saturates.
  always_comb begin
    w_credits_next = r_credits;
    if (w_overflow) begin
      w_credits_next = r_credits;
    end else if (w_send && !credit_i) begin
      w_credits_next = r_credits - lp_cnt_one;
    end else if (!w_send && credit_i) begin
      w_credits_next = r_credits + lp_cnt_one;
    end else begin
      w_credits_next = r_credits;
    end
  end

  // Input FIFO storage and pointers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < buf_els_p; i++) begin
        r_mem[i] <= {width_p{1'b0}};
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_enq) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= f_ptr_inc(r_wr_ptr);
      end
      if (w_send) begin
        r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      end
      r_count <= w_count_next;
    end
  end

  // Output register, credit counter and status flags.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_v       <= 1'b0;
      r_data    <= {width_p{1'b0}};
      r_credits <= lp_credit_max;
      r_ready   <= 1'b1;
      r_drained <= 1'b1;
    end else begin
      r_v <= w_send;
      if (w_send) begin
        r_data <= r_mem[r_rd_ptr];
      end
      r_credits <= w_credits_next;
      r_ready   <= (w_count_next != lp_buf_full);
      // Reflects the state of the previous cycle; the output register is not counted.
      r_drained <= (r_count == 2'd0) & (r_credits == lp_credit_max);
    end
  end

`ifdef BSG_MANYCORE_CREDIT_TX_OVERFLOW_CHECK_EN
  logic r_error;

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_error <= 1'b0;
    end else if (w_overflow) begin
      r_error <= 1'b1;
    end
  end

  // Simulation-only report of an illegal credit return.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && w_overflow) begin
      $error("credit overflow at time %0t", $time);
    end
  end

  assign error_o = r_error;
`else
  assign error_o = 1'b0;
`endif

  assign ready_and_o = r_ready;
  assign v_o         = r_v;
  assign data_o      = r_data;
  assign credits_o   = r_credits;
  assign drained_o   = r_drained;

endmodule

// File: tb/tb_bsg_manycore_ready_to_credit_tx.sv
// Randomised bench for bsg_manycore_ready_to_credit_tx against a queue-based reference model.
module tb_bsg_manycore_ready_to_credit_tx;
  localparam int W = 32;
  localparam int N = 3;
  localparam int B = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         v_i;
  logic [W-1:0] data_i;
  logic         ready_and_o;
  logic         v_o;
  logic [W-1:0] data_o;
  logic         credit_i;
  logic [1:0]   credits_o;
  logic         drained_o;
  logic         error_o;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  // Reference model state: pending packets, credits and expected outputs.
  logic [W-1:0] m_q[$];
  logic [W-1:0] acc_log[$];
  logic [W-1:0] obs_log[$];
  int           m_credits = N;
  bit           m_v = 1'b0, m_ready = 1'b1, m_drained = 1'b1, m_error = 1'b0;
  logic [W-1:0] m_data = '0;

  bsg_manycore_ready_to_credit_tx #(.width_p(W), .credit_els_p(N), .buf_els_p(B)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .data_i(data_i), .ready_and_o(ready_and_o),
    .v_o(v_o), .data_o(data_o), .credit_i(credit_i), .credits_o(credits_o),
    .drained_o(drained_o), .error_o(error_o));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_credits = N; m_v = 1'b0; m_data = '0;
    m_ready = 1'b1; m_drained = 1'b1; m_error = 1'b0;
  endtask

  task automatic model_step();
    int sz;
    bit send, acc;
    sz = m_q.size();
    send = (sz > 0) && (m_credits > 0);
    acc  = v_i && (sz < B);
    m_drained = (sz == 0) && (m_credits == N);
    m_v = send;
    if (send) m_data = m_q.pop_front();
    if (acc) begin
      m_q.push_back(data_i);
      acc_log.push_back(data_i);
    end
    if (credit_i && !send && m_credits == N) begin
`ifdef BSG_MANYCORE_CREDIT_TX_OVERFLOW_CHECK_EN
      m_error = 1'b1;
`endif
    end else begin
      m_credits = m_credits - int'(send) + int'(credit_i);
    end
    m_ready = m_q.size() < B;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // Compare process: every falling edge once reset has been applied.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("v_o", v_o, m_v);
        chk("data_o", data_o, m_data);
        chk("credits_o", credits_o, m_credits);
        chk("ready_and_o", ready_and_o, m_ready);
        chk("drained_o", drained_o, m_drained);
        chk("error_o", error_o, m_error);
        if (v_o === 1'b1) obs_log.push_back(data_o);
      end
    end
  end

  task automatic step(input bit v, input logic [W-1:0] d, input bit c);
    v_i = v; data_i = d; credit_i = c;
    @(posedge clk); #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rst_credits"}, credits_o, 2'd3);
    chk({tag, "_rst_drained"}, drained_o, 1'b1);
    chk({tag, "_rst_ready"}, ready_and_o, 1'b1);
    chk({tag, "_rst_v"}, v_o, 1'b0);
    chk({tag, "_rst_error"}, error_o, 1'b0);
  endtask

  // Entered and left one time unit after a rising edge; reset lands mid-cycle.
  task automatic do_reset(input string tag);
    v_i = 1'b0; data_i = '0; credit_i = 1'b0;
    #2 reset_n = 1'b0;
    #1 reset_checks(tag);
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    acc_log.delete(); obs_log.delete();
  endtask

  task automatic drain_and_compare(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      step(1'b0, '0, (m_credits < N));
      done = (m_q.size() == 0) && (m_credits == N) && !m_v;
    end
    chk({tag, "_drain_timeout"}, done, 1'b1);
    step(1'b0, '0, 1'b0);
    chk({tag, "_count"}, obs_log.size(), acc_log.size());
    for (int i = 0; i < obs_log.size() && i < acc_log.size(); i++)
      chk({tag, "_order"}, obs_log[i], acc_log[i]);
  endtask

  initial begin
    v_i = 1'b0; data_i = '0; credit_i = 1'b0; reset_n = 1'b1;
    #1 reset_n = 1'b0;
    armed = 1'b1;
    #1 reset_checks("t1");
    chk("t1_data", data_o, 32'h0);
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;

    // Three credits spent on A1..A3, A4/A5 held until a credit returns.
    step(1'b1, 32'hA1, 1'b0);
    step(1'b1, 32'hA2, 1'b0);
    step(1'b1, 32'hA3, 1'b0);
    step(1'b1, 32'hA4, 1'b0);
    step(1'b1, 32'hA5, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("t2_sent", obs_log.size(), 3);
    if (obs_log.size() == 3) begin
      chk("t2_p0", obs_log[0], 32'hA1);
      chk("t2_p1", obs_log[1], 32'hA2);
      chk("t2_p2", obs_log[2], 32'hA3);
    end
    chk("t2_credits0", credits_o, 2'd0);
    chk("t2_full", ready_and_o, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("t2_credit_reg", credits_o, 2'd1);
    chk("t2_no_bypass", v_o, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("t2_a4_v", v_o, 1'b1);
    chk("t2_a4_data", data_o, 32'hA4);
    chk("t2_credits_back0", credits_o, 2'd0);

    // Steady streaming with a credit every cycle from the third packet on.
    do_reset("t3");
    while (acc_log.size() < 100) begin
      step(1'b1, $urandom, (acc_log.size() >= 3) && (m_credits < N));
      if (acc_log.size() == 50) begin
        chk("t3_steady_v", v_o, 1'b1);
        chk("t3_steady_credits", credits_o, 2'd1);
      end
    end
    drain_and_compare("t3");

    // Drain timing: drained_o rises one cycle after credits are all home.
    do_reset("t4");
    step(1'b1, 32'hC1, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("t4_busy", drained_o, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("t4_credits_full", credits_o, 2'd3);
    chk("t4_not_yet", drained_o, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("t4_drained", drained_o, 1'b1);

    // Credit overflow at full credits.
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("t5_credits", credits_o, 2'd3);
`ifdef BSG_MANYCORE_CREDIT_TX_OVERFLOW_CHECK_EN
    chk("t5_error", error_o, 1'b1);
`else
    chk("t5_error", error_o, 1'b0);
`endif

    // Random traffic with legal random credit returns.
    do_reset("rnd");
    for (int i = 0; i < 300; i++)
      step($urandom_range(1, 0) == 1, $urandom, (m_credits < N) && ($urandom_range(1, 0) == 1));
    drain_and_compare("rnd");

    // Reset with two packets buffered and one credit available.
    do_reset("t6a");
    step(1'b1, 32'hD1, 1'b0);
    step(1'b1, 32'hD2, 1'b0);
    step(1'b1, 32'hD3, 1'b0);
    step(1'b1, 32'hD4, 1'b0);
    step(1'b1, 32'hD5, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("t6_pre_credits", credits_o, 2'd1);
    chk("t6_pre_full", ready_and_o, 1'b0);
    do_reset("t6");
    step(1'b1, 32'hB0, 1'b0);
    chk("t6_t1_v", v_o, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("t6_t2_v", v_o, 1'b1);
    chk("t6_t2_data", data_o, 32'hB0);
    step(1'b0, '0, 1'b0);
    chk("t6_t3_v", v_o, 1'b0);

    armed = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
